// File: rtl/stc0_ingress_arb.sv
// Frame-level round-robin arbiter for the stc0_core ingress byte port.
// It holds a grant for a whole frame, enforces an idle gap between frames, and aborts stalled frames.
module stc0_ingress_arb #(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic       Clk,
    input  logic       ARst_n,
    input  logic       Enable,
    input  logic       ErrClr,
    input  logic [7:0] R0Data,
    input  logic       R0Valid,
    output logic       R0Ready,
    input  logic [7:0] R1Data,
    input  logic       R1Valid,
    output logic       R1Ready,
    output logic [7:0] ID,
    output logic       IValid,
    output logic [1:0] Grant,
    output logic       Busy,
    output logic       Abort,
    output logic       TimeoutErr
);

    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          lastGnt_q, lastGnt_d;
    logic          hdrSeen_q, hdrSeen_d;
    logic [3:0]    remain_q, remain_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    id_q, id_d;
    logic          ivalid_q, ivalid_d;
    logic          abort_q, abort_d;
    logic          err_q, err_d;

    logic          selValid;
    logic [7:0]    selData;
    logic          frameEnd;

    assign selValid = grant_q[1] ? R1Valid : R0Valid;
    assign selData  = grant_q[1] ? R1Data  : R0Data;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        lastGnt_d = lastGnt_q;
        hdrSeen_d = hdrSeen_q;
        remain_d  = remain_q;
        stall_d   = stall_q;
        gap_d     = gap_q;
        id_d      = id_q;
        ivalid_d  = 1'b0;
        abort_d   = 1'b0;
        frameEnd  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that did not own the previous frame wins.
                if (Enable && (R0Valid || R1Valid)) begin
                    if (R0Valid && R1Valid) begin
                        grant_d = lastGnt_q ? 2'b01 : 2'b10;
                    end else begin
                        grant_d = R0Valid ? 2'b01 : 2'b10;
                    end
                    state_d   = ST_XFER;
                    hdrSeen_d = 1'b0;
                    stall_d   = '0;
                end
            end
            ST_XFER: begin
                if (selValid) begin
                    id_d     = selData;
                    ivalid_d = 1'b1;
                    stall_d  = '0;
                    if (!hdrSeen_q) begin
                        hdrSeen_d = 1'b1;
                        remain_d  = selData[3:0];
                        frameEnd  = (selData[3:0] == 4'd0);
                    end else begin
                        remain_d = remain_q - 4'd1;
                        frameEnd = (remain_q == 4'd1);
                    end
                end else if (stall_q == SW'(TIMEOUT - 1)) begin
                    abort_d  = 1'b1;
                    frameEnd = 1'b1;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
                if (frameEnd) begin
                    state_d   = ST_GAP;
                    grant_d   = 2'b00;
                    lastGnt_d = grant_q[1];
                    gap_d     = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An abort in the same cycle as ErrClr leaves the flag set.
        if (abort_d) begin
            err_d = 1'b1;
        end else if (ErrClr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge Clk or negedge ARst_n) begin
        if (!ARst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            lastGnt_q <= 1'b1;
            hdrSeen_q <= 1'b0;
            remain_q  <= 4'd0;
            stall_q   <= '0;
            gap_q     <= '0;
            id_q      <= 8'd0;
            ivalid_q  <= 1'b0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            lastGnt_q <= lastGnt_d;
            hdrSeen_q <= hdrSeen_d;
            remain_q  <= remain_d;
            stall_q   <= stall_d;
            gap_q     <= gap_d;
            id_q      <= id_d;
            ivalid_q  <= ivalid_d;
            abort_q   <= abort_d;
            err_q     <= err_d;
        end
    end

    assign R0Ready    = (state_q == ST_XFER) && grant_q[0];
    assign R1Ready    = (state_q == ST_XFER) && grant_q[1];
    assign ID         = id_q;
    assign IValid     = ivalid_q;
    assign Grant      = grant_q;
    assign Busy       = (state_q != ST_IDLE);
    assign Abort      = abort_q;
    assign TimeoutErr = err_q;

endmodule

// File: tb/tb_stc0_ingress_arb.sv
// Self-checking bench for stc0_ingress_arb: directed scenarios plus random traffic
// compared cycle by cycle against a frame-level reference model.
module tb_stc0_ingress_arb;

    localparam int GAP     = 2;
    localparam int TIMEOUT = 255;

    logic       Clk = 1'b0;
    logic       ARst_n;
    logic       Enable;
    logic       ErrClr;
    logic [7:0] R0Data;
    logic       R0Valid;
    logic       R0Ready;
    logic [7:0] R1Data;
    logic       R1Valid;
    logic       R1Ready;
    logic [7:0] ID;
    logic       IValid;
    logic [1:0] Grant;
    logic       Busy;
    logic       Abort;
    logic       TimeoutErr;

    int nCompared   = 0;
    int nMismatched = 0;
    int abortSeen   = 0;

    // Reference model: owner (-1 = nobody), bytes still owed, gap cycles left, stall length.
    int         mOwner;
    int         mLast;
    int         mLeft;
    int         mGap;
    int         mStall;
    bit         mIValid;
    bit         mAbort;
    bit         mErr;
    logic [7:0] mID;

    stc0_ingress_arb #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .ARst_n(ARst_n), .Enable(Enable), .ErrClr(ErrClr),
        .R0Data(R0Data), .R0Valid(R0Valid), .R0Ready(R0Ready),
        .R1Data(R1Data), .R1Valid(R1Valid), .R1Ready(R1Ready),
        .ID(ID), .IValid(IValid), .Grant(Grant), .Busy(Busy),
        .Abort(Abort), .TimeoutErr(TimeoutErr)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mOwner  = -1;
        mLast   = 1;
        mLeft   = -1;
        mGap    = 0;
        mStall  = 0;
        mIValid = 1'b0;
        mAbort  = 1'b0;
        mErr    = 1'b0;
        mID     = 8'd0;
    endtask

    task automatic modelStep(input bit r0v, input logic [7:0] r0d, input bit r1v, input logic [7:0] r1d,
                             input bit en, input bit clr);
        bit         v;
        logic [7:0] d;
        mIValid = 1'b0;
        mAbort  = 1'b0;
        if (mOwner >= 0) begin
            v = (mOwner == 0) ? r0v : r1v;
            d = (mOwner == 0) ? r0d : r1d;
            if (v) begin
                mIValid = 1'b1;
                mID     = d;
                mStall  = 0;
                if (mLeft < 0) mLeft = int'(d[3:0]);
                else mLeft = mLeft - 1;
                if (mLeft == 0) begin
                    mLast  = mOwner;
                    mOwner = -1;
                    mGap   = GAP;
                end
            end else begin
                mStall = mStall + 1;
                if (mStall == TIMEOUT) begin
                    mAbort = 1'b1;
                    mLast  = mOwner;
                    mOwner = -1;
                    mGap   = GAP;
                end
            end
        end else if (mGap > 0) begin
            mGap = mGap - 1;
        end else if (en && (r0v || r1v)) begin
            if (r0v && r1v) mOwner = 1 - mLast;
            else mOwner = r0v ? 0 : 1;
            mLeft  = -1;
            mStall = 0;
        end
        if (mAbort) mErr = 1'b1;
        else if (clr) mErr = 1'b0;
    endtask

    task automatic checkAll();
        logic [1:0] expGrant;
        expGrant = (mOwner < 0) ? 2'b00 : ((mOwner == 0) ? 2'b01 : 2'b10);
        checkOutput("Grant",      32'(Grant),      32'(expGrant));
        checkOutput("IValid",     32'(IValid),     32'(mIValid));
        checkOutput("ID",         32'(ID),         32'(mID));
        checkOutput("Busy",       32'(Busy),       32'((mOwner >= 0) || (mGap > 0)));
        checkOutput("R0Ready",    32'(R0Ready),    32'(mOwner == 0));
        checkOutput("R1Ready",    32'(R1Ready),    32'(mOwner == 1));
        checkOutput("Abort",      32'(Abort),      32'(mAbort));
        checkOutput("TimeoutErr", 32'(TimeoutErr), 32'(mErr));
        if (Abort === 1'b1) abortSeen++;
    endtask

    task automatic applyStimulus(input bit r0v, input logic [7:0] r0d, input bit r1v, input logic [7:0] r1d,
                                 input bit en, input bit clr);
        @(negedge Clk);
        R0Valid = r0v;
        R0Data  = r0d;
        R1Valid = r1v;
        R1Data  = r1d;
        Enable  = en;
        ErrClr  = clr;
        #1;
        checkAll();
        modelStep(r0v, r0d, r1v, r1d, en, clr);
    endtask

    task automatic doAsyncReset();
        @(negedge Clk);
        #2;
        ARst_n  = 1'b0;
        R0Valid = 1'b0;
        R1Valid = 1'b0;
        ErrClr  = 1'b0;
        #1;
        checkOutput("rst_IValid",  32'(IValid),  32'd0);
        checkOutput("rst_Grant",   32'(Grant),   32'd0);
        checkOutput("rst_Busy",    32'(Busy),    32'd0);
        checkOutput("rst_R0Ready", 32'(R0Ready), 32'd0);
        checkOutput("rst_R1Ready", 32'(R1Ready), 32'd0);
        modelReset();
        @(negedge Clk);
        #3;
        ARst_n = 1'b1;
    endtask

    initial begin
        ARst_n  = 1'b1;
        Enable  = 1'b1;
        ErrClr  = 1'b0;
        R0Valid = 1'b0;
        R1Valid = 1'b0;
        R0Data  = 8'd0;
        R1Data  = 8'd0;
        modelReset();
        #1;
        doAsyncReset();
        checkOutput("rst_ID", 32'(ID), 32'd0);
        checkOutput("rst_TimeoutErr", 32'(TimeoutErr), 32'd0);

        $display("[TB] single R0 frame, header 0x03");
        applyStimulus(1, 8'h03, 0, 8'h00, 1, 0);
        applyStimulus(1, 8'h03, 0, 8'h00, 1, 0);
        applyStimulus(1, 8'hB1, 0, 8'h00, 1, 0);
        applyStimulus(1, 8'hB2, 0, 8'h00, 1, 0);
        applyStimulus(1, 8'hB3, 0, 8'h00, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);

        $display("[TB] both requesters, header 0x01 frames");
        for (int i = 0; i < 24; i++) applyStimulus(1, 8'h01, 1, 8'h01, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);

        $display("[TB] zero-length frames");
        for (int i = 0; i < 10; i++) applyStimulus(1, 8'h00, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);

        $display("[TB] R1 stalls mid-frame");
        applyStimulus(0, 8'h00, 1, 8'h05, 1, 0);
        applyStimulus(0, 8'h00, 1, 8'h05, 1, 0);
        applyStimulus(0, 8'h00, 1, 8'hC1, 1, 0);
        applyStimulus(0, 8'h00, 1, 8'hC2, 1, 0);
        for (int i = 0; i < TIMEOUT + 6; i++) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        checkOutput("abort_seen", 32'(abortSeen), 32'd1);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);

        $display("[TB] Enable dropped mid-frame");
        applyStimulus(1, 8'h02, 0, 8'h00, 1, 0);
        applyStimulus(1, 8'h02, 0, 8'h00, 0, 0);
        applyStimulus(1, 8'hD1, 0, 8'h00, 0, 0);
        applyStimulus(1, 8'hD2, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'h01, 0, 8'h00, 0, 0);
        applyStimulus(1, 8'h01, 0, 8'h00, 1, 0);
        applyStimulus(1, 8'h01, 0, 8'h00, 1, 0);
        applyStimulus(1, 8'h01, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);

        $display("[TB] async reset mid-frame");
        applyStimulus(0, 8'h00, 1, 8'h0F, 1, 0);
        applyStimulus(0, 8'h00, 1, 8'h0F, 1, 0);
        applyStimulus(0, 8'h00, 1, 8'h11, 1, 0);
        doAsyncReset();
        for (int i = 0; i < 12; i++) applyStimulus(1, 8'h01, 1, 8'h01, 1, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom()) & 8'hF7,
                          ($urandom_range(0, 9) < 7), 8'($urandom()) & 8'hF7,
                          ($urandom_range(0, 19) != 0), ($urandom_range(0, 19) == 0));
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
